// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and reset constants for the multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Every bit of HI/LO takes this value on reset.
    localparam logic RESULT_RESET_BIT = 1'b0;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module mdu_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] opreg,
    input  logic [DATA_WIDTH-1:0] operand,
    input  logic                  is_div,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic [DATA_WIDTH-1:0] opreg_next
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                fits;

    always_comb begin
        sum     = {1'b0, acc} + (opreg[0] ? {1'b0, operand} : '0);
        shifted = {acc, opreg[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        fits    = shifted >= {1'b0, operand};
        if (is_div) begin
            // Remainder stays below the divisor, so the difference always fits DATA_WIDTH bits.
            acc_next   = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            opreg_next = {opreg[DATA_WIDTH-2:0], fits};
        end else begin
            acc_next   = sum[DATA_WIDTH:1];
            opreg_next = {sum[0], opreg[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_mul_div_unit.sv
// rtl/iter_mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module iter_mul_div_unit
    import mdu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_by_zero
);

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state, state_next;
    logic [CNT_WIDTH-1:0]    count;
    logic                    div_q, neg_q, rem_neg_q, zero_q;
    logic [DATA_WIDTH-1:0]   acc_q, opreg_q, operand_q;
    logic [DATA_WIDTH-1:0]   acc_next, opreg_next;
    logic                    accept, signed_op, is_div, in1_neg, in2_neg;
    logic [DATA_WIDTH-1:0]   mag1, mag2;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   hi_fix, lo_fix;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST_STEP) state_next = FIN;
            FIN:     state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = start && (state != RUN);
    end

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIVU) || (op == OP_DIV);
        in1_neg   = signed_op && in1[DATA_WIDTH-1];
        in2_neg   = signed_op && in2[DATA_WIDTH-1];
        mag1      = in1_neg ? -in1 : in1;
        mag2      = in2_neg ? -in2 : in2;
    end

    mdu_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .acc        (acc_q),
        .opreg      (opreg_q),
        .operand    (operand_q),
        .is_div     (div_q),
        .acc_next   (acc_next),
        .opreg_next (opreg_next)
    );

    // Sign fix-up on the magnitude result; remainder follows the dividend's sign.
    always_comb begin
        prod_fix = neg_q ? -{acc_q, opreg_q} : {acc_q, opreg_q};
        if (div_q) begin
            hi_fix = rem_neg_q ? -acc_q : acc_q;
            lo_fix = zero_q ? '1 : (neg_q ? -opreg_q : opreg_q);
        end else begin
            hi_fix = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_fix = prod_fix[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            div_q       <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            opreg_q     <= '0;
            operand_q   <= '0;
            hi          <= {DATA_WIDTH{RESULT_RESET_BIT}};
            lo          <= {DATA_WIDTH{RESULT_RESET_BIT}};
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                acc_q   <= acc_next;
                opreg_q <= opreg_next;
                count   <= count + 1'b1;
            end
            if (accept) begin
                count       <= '0;
                div_q       <= is_div;
                neg_q       <= in1_neg ^ in2_neg;
                rem_neg_q   <= in1_neg;
                zero_q      <= is_div && (in2 == '0);
                acc_q       <= '0;
                opreg_q     <= is_div ? mag1 : mag2;
                operand_q   <= is_div ? mag2 : mag1;
                div_by_zero <= 1'b0;
            end
            // A finishing op's flag wins over the clear from a back-to-back start.
            if (state == FIN) begin
                hi          <= hi_fix;
                lo          <= lo_fix;
                done        <= 1'b1;
                div_by_zero <= zero_q;
            end
        end
    end

endmodule

// File: tb/tb_iter_mul_div_unit.sv
// tb/tb_iter_mul_div_unit.sv - self-checking bench: vector table, corner sequences, random ops vs arithmetic model
module tb_iter_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    iter_mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {dbz, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); in1 = $urandom; in2 = $urandom;
        check({name, " dbz_clear"}, {63'b0, div_by_zero}, 64'd0);
        check({name, " busy_on"}, {63'b0, busy}, 64'd1);
    endtask

    // Called right after the accepting edge; optionally pokes start at a given cycle.
    task automatic wait_result(input logic [31:0] eh, input logic [31:0] el, input logic ed, input string name,
                               input int poke, input logic [1:0] po, input logic [31:0] pa, input logic [31:0] pb);
        int edges = 0;
        int busy_cnt = 0;
        bit seen = 0;
        while (!seen && edges < 100) begin
            if (edges == poke) begin
                start = 1'b1; op = po; in1 = pa; in2 = pb;
            end else if (edges == poke + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(edges), 64'd33);
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({name, " hi"}, {32'b0, hi}, {32'b0, eh});
        check({name, " lo"}, {32'b0, lo}, {32'b0, el});
        check({name, " dbz"}, {63'b0, div_by_zero}, {63'b0, ed});
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, input string name);
        launch(o, a, b, name);
        wait_result(eh, el, ed, name, -1, 2'b00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, " done_pulse"}, {63'b0, done}, 64'd0);
        check({name, " hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        logic [64:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          pulses;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
        vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset dbz", {63'b0, div_by_zero}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                  $sformatf("vec%0d", i));

        // start pulsed while busy must not disturb the in-flight MULTU
        launch(2'b00, 32'h1234_5678, 32'h0000_1000, "ignore");
        wait_result(32'h0000_0123, 32'h4567_8000, 1'b0, "ignore", 4, 2'b11, 32'hDEAD_BEEF, 32'h0000_0003);

        // start held in the FIN cycle is accepted back-to-back
        launch(2'b00, 32'h0000_0010, 32'h0000_0011, "b2b_first");
        wait_result(32'h0, 32'h0000_0110, 1'b0, "b2b_first", 32, 2'b01, 32'hFFFF_FFFE, 32'h0000_0007);
        m = model(2'b01, 32'hFFFF_FFFE, 32'h0000_0007);
        wait_result(m[63:32], m[31:0], m[64], "b2b_second", -1, 2'b00, 32'd0, 32'd0);

        // reset mid-divide aborts with no done pulse
        launch(2'b11, 32'h7FFF_0000, 32'h0000_0123, "rst_div");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_abort busy", {63'b0, busy}, 64'd0);
        check("rst_abort done", {63'b0, done}, 64'd0);
        check("rst_abort hilo", {hi, lo}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("rst_abort quiet", 64'(pulses), 64'd0);
        do_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            m = model(ro, ra, rb);
            do_op(ro, ra, rb, m[63:32], m[31:0], m[64], $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
